// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the exception/interrupt sequencer: ExcCodes, FSM
// state encoding, default exception vector and the prioritised-event record.
package exc_ctrl_pkg;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ENTER   = 2'd1;
  localparam logic [1:0] ST_HANDLER = 2'd2;
  localparam logic [1:0] ST_RETURN  = 2'd3;

  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_0380;

  typedef struct packed {
    logic       valid;
    logic       is_irq;
    logic [4:0] cause;
    logic [2:0] irq_id;
  } event_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: picks the highest-priority exception or the
// lowest-numbered pending (already masked) interrupt.
module exc_prio_enc
  import exc_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 6
) (
  input  logic               exc_ovf,
  input  logic               exc_ri,
  input  logic               exc_sys,
  input  logic [NUM_IRQ-1:0] irq_pend,
  output event_t             evt
);

  logic [2:0] low_id;

  // Scan from the top down so the last hit is the lowest pending index.
  always_comb begin
    low_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pend[i]) low_id = 3'(i);
    end
  end

  always_comb begin
    evt = '0;
    if (exc_ovf) begin
      evt.valid = 1'b1;
      evt.cause = EXC_OV;
    end else if (exc_ri) begin
      evt.valid = 1'b1;
      evt.cause = EXC_RI;
    end else if (exc_sys) begin
      evt.valid = 1'b1;
      evt.cause = EXC_SYS;
    end else if (|irq_pend) begin
      evt.valid  = 1'b1;
      evt.is_irq = 1'b1;
      evt.cause  = EXC_INT;
      evt.irq_id = low_id;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: IDLE -> ENTER -> HANDLER -> RETURN.
// Define EXC_CTRL_IRQ_SYNC_EN to pass irq through a 2-flop synchroniser.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int                 NUM_IRQ      = 6,
  parameter logic [31:0]        HANDLER_ADDR = HANDLER_ADDR_DEF,
  parameter logic [NUM_IRQ-1:0] IRQ_MASK_RST = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               exc_ovf,
  input  logic               exc_ri,
  input  logic               exc_sys,
  input  logic [31:0]        exc_pc,
  input  logic [31:0]        next_pc,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               irq_mask_we,
  input  logic [NUM_IRQ-1:0] irq_mask_wdata,
  input  logic               eret,
  input  logic [31:0]        epc_in,
  output logic               epc_write,
  output logic [31:0]        epc_pc,
  output logic               flush,
  output logic               pc_redirect,
  output logic [31:0]        redirect_pc,
  output logic [4:0]         cause,
  output logic [2:0]         irq_id,
  output logic               exl,
  output logic [NUM_IRQ-1:0] irq_mask
);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [NUM_IRQ-1:0] irq_eff;
  event_t             evt;

`ifdef EXC_CTRL_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] irq_s1;
  logic [NUM_IRQ-1:0] irq_s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_s1 <= '0;
      irq_s2 <= '0;
    end else begin
      irq_s1 <= irq;
      irq_s2 <= irq_s1;
    end
  end

  assign irq_eff = irq_s2;
`else
  assign irq_eff = irq;
`endif

  exc_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .exc_ovf  (exc_ovf),
    .exc_ri   (exc_ri),
    .exc_sys  (exc_sys),
    .irq_pend (irq_eff & irq_mask),
    .evt      (evt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (evt.valid) state_nxt = ST_ENTER;
      ST_ENTER:   state_nxt = ST_HANDLER;
      ST_HANDLER: if (eret) state_nxt = ST_RETURN;
      ST_RETURN:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Mask writes land after this cycle's detection has already used the old mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      epc_pc   <= '0;
      cause    <= '0;
      irq_id   <= '0;
      irq_mask <= IRQ_MASK_RST;
    end else begin
      state <= state_nxt;
      if (irq_mask_we) irq_mask <= irq_mask_wdata;
      if (state == ST_IDLE && evt.valid) begin
        epc_pc <= evt.is_irq ? next_pc : exc_pc;
        cause  <= evt.cause;
        irq_id <= evt.irq_id;
      end
    end
  end

  assign epc_write   = (state == ST_ENTER);
  assign flush       = (state == ST_ENTER) || (state == ST_RETURN);
  assign pc_redirect = flush;
  assign exl         = (state != ST_IDLE);
  assign redirect_pc = (state == ST_ENTER)  ? HANDLER_ADDR :
                       (state == ST_RETURN) ? epc_in : 32'h0;

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer for the single-cycle MIPS-style core.
- Sits between the execute/commit stage and the `epc` register.
- Prioritises synchronous exceptions and masked external interrupts, and drives the EPC write strobe and captured PC.
- Flushes the pipeline and redirects fetch to the handler; on ERET, redirects fetch back to the EPC value.

Parameters:
- NUM_IRQ, 6, number of external interrupt lines (1..8).
- HANDLER_ADDR, 32'h0000_0380, fixed exception vector.
- IRQ_MASK_RST, 0, reset value of the interrupt mask (1 = enabled).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; reset==0 clears all state.
- exc_ovf  in  1  arithmetic overflow in the committing instruction.
- exc_ri  in  1  reserved/illegal instruction.
- exc_sys  in  1  syscall.
- exc_pc  in  32  PC of the faulting instruction.
- next_pc  in  32  PC of the next instruction to commit; this is the interrupt return point.
- irq  in  NUM_IRQ  level-sensitive external interrupt requests.
- irq_mask_we  in  1  mask write strobe.
- irq_mask_wdata  in  NUM_IRQ  new mask value.
- eret  in  1  ERET committing.
- epc_in  in  32  current EPC register value.
- epc_write  out  1  EPC load strobe.
- epc_pc  out  32  value to load into EPC.
- flush  out  1  kill in-flight instruction(s).
- pc_redirect  out  1  fetch must take redirect_pc.
- redirect_pc  out  32  fetch target.
- cause  out  5  ExcCode of the last taken event.
- irq_id  out  3  index of the taken interrupt.
- exl  out  1  handler in progress.
- irq_mask  out  NUM_IRQ  current mask.

Behaviour:
- Reset: state=IDLE.
  - epc_write, flush, pc_redirect, exl = 0.
  - epc_pc, redirect_pc = 0; cause, irq_id = 0.
  - irq_mask = IRQ_MASK_RST.
- Reset is asynchronous, so it may arrive mid-sequence. It forces IDLE immediately; any event in progress is dropped and the EPC is not written.
- States:
  - IDLE: normal execution.
  - ENTER: 1 cycle.
  - HANDLER: exl=1.
  - RETURN: 1 cycle.
- IDLE, event detection at cycle N. Priority, highest first:
  - exc_ovf (cause 12)
  - exc_ri (cause 10)
  - exc_sys (cause 8)
  - interrupt (cause 0)
- An interrupt is pending when |(irq & irq_mask) != 0. irq_id is the lowest pending index.
- On a taken event:
  - Register epc_pc (exc_pc for exceptions, next_pc for interrupts), cause and irq_id.
  - Go to ENTER at N+1.
- ENTER (cycle N+1):
  - epc_write=1, flush=1, pc_redirect=1, redirect_pc=HANDLER_ADDR, exl=1.
  - Next state is HANDLER. Entry latency is 1 cycle from detection to strobe.
- HANDLER:
  - Exceptions and interrupts are ignored; interrupts stay pending because they are level-sensitive.
  - eret=1 goes to RETURN.
  - If eret and an exception are asserted in the same cycle, eret wins.
- RETURN (1 cycle):
  - flush=1, pc_redirect=1, redirect_pc=epc_in sampled that cycle, exl=1.
  - Next state is IDLE, and exl drops to 0.
  - An interrupt still pending is taken in the following IDLE cycle.
- eret in IDLE is ignored; no redirect is issued.
- epc_write, flush and pc_redirect are single-cycle pulses, deasserted in all other states.
- irq_mask:
  - Updated on any cycle in which irq_mask_we=1; the new value is visible the next cycle.
  - Detection uses the registered mask.
  - A write in the same cycle as detection does not affect that cycle's detection.
- cause and irq_id hold until the next taken event.

Optional Feature:
- Macro: EXC_CTRL_IRQ_SYNC_EN.
- Defined: each irq bit passes through a 2-flop synchroniser (reset to 0) before masking. This adds 2 cycles of interrupt latency.
- Undefined: irq is used directly and is required to be synchronous to clk.

Decomposition:
- Shared package holds:
  - ExcCode constants: EXC_INT=0, EXC_SYS=8, EXC_RI=10, EXC_OV=12.
  - The state encoding: IDLE, ENTER, HANDLER, RETURN.
  - HANDLER_ADDR default.
- One sub-module: exc_prio_enc. It is combinational and produces the highest-priority event, its cause and irq_id from the exception bits and the masked irq vector.

Test Plan:
- exc_ovf=1 and exc_sys=1 with exc_pc=0x0000_1004 in IDLE -> next cycle:
  - epc_write=1, epc_pc=0x0000_1004, cause=12, redirect_pc=0x380, flush=1, exl=1.
  - Then HANDLER.
- mask=6'b000100, irq=6'b000110, next_pc=0x2000 -> cause=0, irq_id=2, epc_pc=0x2000. Then, with irq=6'b000010 alone, no event is taken.
- In HANDLER, pulse exc_ri=1 -> no strobe. Then eret=1 with epc_in=0x2000 -> next cycle:
  - pc_redirect=1, redirect_pc=0x2000, flush=1.
  - The cycle after: IDLE with exl=0.
- eret=1 in IDLE -> pc_redirect stays 0 and state stays IDLE.
- Assert reset=0 during ENTER -> all outputs 0 immediately and irq_mask=IRQ_MASK_RST. After release with no events, state is IDLE.
- With EXC_CTRL_IRQ_SYNC_EN defined, irq rising at cycle 0 with mask enabled -> epc_write asserts at cycle 3.
